// File: rtl/ks_pkg.sv
// Shared constants for the Karplus-Strong string model: FSM encodings,
// LFSR tap positions and default seed, plus the LFSR step function.
package ks_pkg;

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] BURST   = 2'd1;
    localparam logic [1:0] SUSTAIN = 2'd2;
    localparam logic [1:0] FLUSH   = 2'd3;

    localparam int LFSR_W  = 8;
    localparam int LFSR_T0 = 7;
    localparam int LFSR_T1 = 5;
    localparam int LFSR_T2 = 4;
    localparam int LFSR_T3 = 3;

    localparam logic [LFSR_W-1:0] KS_DEFAULT_SEED = 8'hA5;

    // Fibonacci step: shift left, feed the XOR of the taps into bit 0.
    function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] v);
        return {v[LFSR_W-2:0], v[LFSR_T0] ^ v[LFSR_T1] ^ v[LFSR_T2] ^ v[LFSR_T3]};
    endfunction

endpackage

// File: rtl/ks_lfsr.sv
// 8-bit Fibonacci LFSR noise source; steps only when adv_i is high so the
// sequence carries on across notes.
module ks_lfsr
    import ks_pkg::*;
#(
    parameter logic [LFSR_W-1:0] SEED = KS_DEFAULT_SEED
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              adv_i,
    output logic [LFSR_W-1:0] value_o
);

    logic [LFSR_W-1:0] lfsr_q;
    logic [LFSR_W-1:0] lfsr_d;

    assign lfsr_d  = adv_i ? lfsr_next(lfsr_q) : lfsr_q;
    assign value_o = lfsr_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lfsr_q <= SEED;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

endmodule

// File: rtl/ks_pluck_feedback.sv
// Karplus-Strong excitation/feedback controller: noise burst on pluck, then
// two-point averaging feedback, then a zero flush to clear the delay line.
module ks_pluck_feedback
    import ks_pkg::*;
#(
    parameter int          L           = 4,
    parameter int          B           = 8,
    parameter logic [7:0]  LFSR_SEED   = KS_DEFAULT_SEED,
    parameter int          SUSTAIN_MAX = 1024
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         pluck,
    input  logic [B-1:0] dl_out,
    output logic [B-1:0] dl_in,
    output logic         busy,
    output logic         done
);

    localparam int CNT_MAX = (L > SUSTAIN_MAX) ? L : SUSTAIN_MAX;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0] LINE_LAST    = CNT_W'(L - 1);
    localparam logic [CNT_W-1:0] SUSTAIN_LAST = CNT_W'(SUSTAIN_MAX - 1);

    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [B-1:0]     dl_in_q, dl_in_d;
    logic [B-1:0]     dl_prev_q;
    logic             done_q, done_d;

    logic             lfsr_adv;
    logic [B-1:0]     lfsr_val;
    logic [B:0]       sum;
    logic [B-1:0]     avg;

    ks_lfsr #(
        .SEED (LFSR_SEED)
    ) u_lfsr (
        .clk     (clk),
        .rst_n   (rst_n),
        .adv_i   (lfsr_adv),
        .value_o (lfsr_val)
    );

    // Extra bit keeps FF+FF from wrapping before the halving.
    assign sum = {1'b0, dl_out} + {1'b0, dl_prev_q};
    assign avg = B'(sum >> 1);

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        dl_in_d  = dl_in_q;
        done_d   = 1'b0;
        lfsr_adv = 1'b0;

        case (state_q)
            IDLE: begin
                dl_in_d = '0;
                if (pluck) begin
                    dl_in_d  = lfsr_val;
                    lfsr_adv = 1'b1;
                    cnt_d    = CNT_W'(1);
                    state_d  = BURST;
                end
            end
            BURST: begin
                dl_in_d  = lfsr_val;
                lfsr_adv = 1'b1;
                if (cnt_q == LINE_LAST) begin
                    state_d = SUSTAIN;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            SUSTAIN: begin
                // A re-pluck restarts the burst with the continuing noise.
                if (pluck) begin
                    dl_in_d  = lfsr_val;
                    lfsr_adv = 1'b1;
                    cnt_d    = CNT_W'(1);
                    state_d  = BURST;
                end else begin
                    dl_in_d = avg;
                    if (cnt_q == SUSTAIN_LAST) begin
                        state_d = FLUSH;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            FLUSH: begin
                dl_in_d = '0;
                if (cnt_q == LINE_LAST) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
                dl_in_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            dl_in_q   <= '0;
            dl_prev_q <= '0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            dl_in_q   <= dl_in_d;
            dl_prev_q <= dl_out;
            done_q    <= done_d;
        end
    end

    assign dl_in = dl_in_q;
    assign done  = done_q;
    assign busy  = (state_q != IDLE);

endmodule
